switch_scheduler: RTL

//  Wormhole switch scheduler for the 5-port router. Per output port: packet lock, downstream credit count, round-robin pick.

---
 rtl/rnoc_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/switch_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rnoc_pkg.sv
// Shared router definitions: port indices, flit type encoding and flit field offsets.
package rnoc_pkg;

    localparam int PORT_NUM = 5;

    localparam int P_XP    = 0;
    localparam int P_XM    = 1;
    localparam int P_YM    = 2;
    localparam int P_YP    = 3;
    localparam int P_LOCAL = 4;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    localparam int FLIT_TYPE_LSB = 0;
    localparam int FLIT_TYPE_MSB = 1;
    localparam int NXT_HOP_LSB   = 2;
    localparam int NXT_HOP_MSB   = 6;
    localparam int DST_X_LSB     = 7;
    localparam int DST_X_MSB     = 8;
    localparam int DST_Y_LSB     = 9;
    localparam int DST_Y_MSB     = 10;
    localparam int VCX_LSB       = 11;
    localparam int VCX_MSB       = 15;

    function automatic logic [2:0] port_inc(input logic [2:0] p);
        return (p == 3'(PORT_NUM - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: first requester at or after ptr_i wins, wrapping modulo N.
module rr_arbiter
    import rnoc_pkg::*;
#(
    parameter int N  = PORT_NUM,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/switch_scheduler.sv
// Wormhole switch scheduler: per-output packet lock, downstream credits and round-robin pick.
// state      | meaning
// OUT_IDLE   | output free; HEAD/SINGLE requesters arbitrated round-robin
// OUT_LOCKED | output owned by one input until its TAIL crosses
module switch_scheduler
    import rnoc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter bit LOCAL_INF = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORT_NUM-1:0]      req_valid_i,
    input  logic [PORT_NUM-1:0][2:0] req_port_i,
    input  logic [PORT_NUM-1:0][1:0] req_ftype_i,
    input  logic [PORT_NUM-1:0]      credit_in_i,
    output logic [PORT_NUM-1:0]      grant_o,
    output logic [PORT_NUM-1:0][2:0] xbar_sel_o,
    output logic [PORT_NUM-1:0]      xbar_valid_o,
    output logic                     err_proto_o
);

    localparam int             CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0]  CRED_MAX = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]  CRED_ONE = CW'(1);

    out_state_e                          state_q [PORT_NUM];
    logic [PORT_NUM-1:0][2:0]            owner_q;
    logic [PORT_NUM-1:0][2:0]            rr_q;
    logic [PORT_NUM-1:0][CW-1:0]         credit_q;
    logic [PORT_NUM-1:0][CW-1:0]         credit_d;
    logic                                err_q;
    logic                                err_set;

    logic [PORT_NUM-1:0]                 port_ok;
    logic [PORT_NUM-1:0]                 is_head;
    logic [PORT_NUM-1:0]                 avail;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]   to_out;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]   arb_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]   arb_gnt;
    logic [PORT_NUM-1:0]                 arb_valid;
    logic [PORT_NUM-1:0][2:0]            arb_idx;

    function automatic logic uses_credit(input int o);
        return !(LOCAL_INF && (o == P_LOCAL));
    endfunction

    always_comb begin
        port_ok = '0;
        is_head = '0;
        avail   = '0;
        to_out  = '0;
        arb_req = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            port_ok[i] = (req_port_i[i] < 3'(PORT_NUM));
            is_head[i] = (req_ftype_i[i] == FT_HEAD) || (req_ftype_i[i] == FT_SINGLE);
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            avail[o] = !uses_credit(o) || (credit_q[o] != '0);
            for (int i = 0; i < PORT_NUM; i++) begin
                to_out[o][i] = req_valid_i[i] && port_ok[i] && (req_port_i[i] == 3'(o));
            end
            // A locked output only ever sees its owner; the arbiter then trivially picks it.
            if (state_q[o] == OUT_IDLE) begin
                arb_req[o] = to_out[o] & is_head & {PORT_NUM{avail[o]}};
            end else begin
                arb_req[o][owner_q[o]] = to_out[o][owner_q[o]] && !is_head[owner_q[o]] && avail[o];
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
        rr_arbiter #(
            .N (PORT_NUM),
            .IW(3)
        ) u_arb (
            .req_i  (arb_req[g]),
            .ptr_i  (rr_q[g]),
            .gnt_o  (arb_gnt[g]),
            .valid_o(arb_valid[g]),
            .idx_o  (arb_idx[g])
        );
    end

    always_comb begin
        grant_o      = '0;
        xbar_valid_o = '0;
        xbar_sel_o   = '0;
        if (rst_ni) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                grant_o         = grant_o | arb_gnt[o];
                xbar_valid_o[o] = arb_valid[o];
                xbar_sel_o[o]   = arb_idx[o];
            end
        end
    end

    always_comb begin
        err_set  = 1'b0;
        credit_d = credit_q;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (req_valid_i[i] && !port_ok[i]) err_set = 1'b1;
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (to_out[o][i] && !is_head[i] &&
                    ((state_q[o] == OUT_IDLE) || (owner_q[o] != 3'(i)))) err_set = 1'b1;
            end
            if ((state_q[o] == OUT_LOCKED) && to_out[o][owner_q[o]] && is_head[owner_q[o]])
                err_set = 1'b1;
            if (uses_credit(o)) begin
                if (arb_valid[o] && !credit_in_i[o]) begin
                    credit_d[o] = credit_q[o] - CRED_ONE;
                end else if (!arb_valid[o] && credit_in_i[o]) begin
                    if (credit_q[o] == CRED_MAX) err_set = 1'b1;
                    else                         credit_d[o] = credit_q[o] + CRED_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                state_q[o]  <= OUT_IDLE;
                owner_q[o]  <= '0;
                rr_q[o]     <= '0;
                credit_q[o] <= CRED_MAX;
            end
            err_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_q | err_set;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (arb_valid[o]) begin
                    case (state_q[o])
                        OUT_IDLE: begin
                            rr_q[o] <= port_inc(arb_idx[o]);
                            if (req_ftype_i[arb_idx[o]] == FT_HEAD) begin
                                state_q[o] <= OUT_LOCKED;
                                owner_q[o] <= arb_idx[o];
                            end
                        end
                        OUT_LOCKED: begin
                            if (req_ftype_i[owner_q[o]] == FT_TAIL) state_q[o] <= OUT_IDLE;
                        end
                        default: state_q[o] <= OUT_IDLE;
                    endcase
                end
            end
        end
    end

    assign err_proto_o = err_q;

endmodule
